neuron_accum_multi: RTL and testbench

NEURON_ACCUM_MULTI -- requirements
Module: neuron_accum_multi

---
 rtl/neuron_accum_pkg.sv | 46 ++++
 rtl/neuron_accum_multi_lane.sv | 50 +++++
 rtl/neuron_accum_multi.sv | 140 ++++++++++++++
 tb/tb_neuron_accum_multi.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/neuron_accum_pkg.sv
// Shared definitions for the multi-lane neuron accumulator: state
// encodings, width helpers and the bit positions of the input beat fields.
package neuron_accum_pkg;

   typedef enum logic {
      G_IDLE,
      G_ACC
   } g_state_t;

   typedef enum logic {
      O_EMPTY,
      O_FULL
   } o_state_t;

   // Width of the mode-dependent control field (sub plus optional shift).
   function automatic int sw_of(input bit rc);
      return rc ? 2 : 1;
   endfunction

   // Lane accumulator width: room for NA full terms plus one shift bit.
   function automatic int aw_of(input int na, input int wd);
      return $clog2(na) + wd + 1;
   endfunction

   // Input beat width: leap, last, control field and all lane weights.
   function automatic int dw_of(input bit rc, input int nb, input int wd);
      return 2 + sw_of(rc) + nb * wd;
   endfunction

   function automatic int idx_leap(input int dw);
      return dw - 1;
   endfunction

   function automatic int idx_last(input int dw);
      return dw - 2;
   endfunction

   function automatic int idx_sub(input int nb, input int wd);
      return nb * wd;
   endfunction

   function automatic int idx_shift(input int nb, input int wd);
      return nb * wd + 1;
   endfunction

endpackage

// File: rtl/neuron_accum_multi_lane.sv
// One accumulator lane: adds or subtracts a zero-extended term each valid
// beat, wrapping or clamping on overflow, and clears when a group closes.
module accum_lane #(
   parameter int AW  = 5,
   parameter int WD  = 2,
   parameter int SAT = 0
) (
   input  logic          iCLK,
   input  logic          iRST,
   input  logic          init,
   input  logic          valid,
   input  logic          sub,
   input  logic [WD:0]   data,
   output logic [AW-1:0] acc,
   output logic          ovf
);

   logic [AW-1:0] acc_q;
   logic [AW-1:0] ext;
   logic [AW:0]   sum;
   logic [AW:0]   diff;

   assign ext = AW'(data);

   // Value of the lane after the current beat, with overflow detection.
   always_comb begin
      sum  = {1'b0, acc_q} + {1'b0, ext};
      diff = {1'b0, acc_q} - {1'b0, ext};
      acc  = acc_q;
      ovf  = 1'b0;
      if (valid) begin
         if (sub) begin
            ovf = diff[AW];
            acc = (diff[AW] && SAT != 0) ? '0 : diff[AW-1:0];
         end else begin
            ovf = sum[AW];
            acc = (sum[AW] && SAT != 0) ? '1 : sum[AW-1:0];
         end
      end
   end

   // Hold the running sum; a closing beat restarts the lane from zero.
   always_ff @(posedge iCLK) begin
      if (iRST || init)
         acc_q <= '0;
      else if (valid)
         acc_q <= acc;
   end

endmodule

// File: rtl/neuron_accum_multi.sv
// Multi-lane neuron accumulator: sums weighted beats across NB lanes into
// groups closed by "last" markers or a leap beat, and presents each group
// result in a single-entry output register with valid/ready handshake.
module neuron_accum_multi
   import neuron_accum_pkg::*;
#(
   parameter int    NA   = 4,
   parameter int    NB   = 4,
   parameter int    WD   = 2,
   parameter int    NI   = 1,
   parameter string MODE = "rc",
   parameter int    SAT  = 0
) (
   input  logic                                     iCLK,
   input  logic                                     iRST,
   input  logic                                     iValid_AS,
   output logic                                     oReady_AS,
   input  logic [2+sw_of(MODE=="rc")+NB*WD-1:0]     iData_AS,
   output logic                                     oValid_BS,
   input  logic                                     iReady_BS,
   output logic [NB*aw_of(NA,WD)-1:0]               oData_BS,
   output logic                                     oLeap_BS,
   output logic                                     oOvf_BS
);

   localparam bit RC = (MODE == "rc");
   localparam int SW = sw_of(RC);
   localparam int AW = aw_of(NA, WD);
   localparam int DW = 2 + SW + NB * WD;
   localparam int LW = $clog2(NI + 1);
   localparam int TW = $clog2(NA + 2);
   localparam logic [LW-1:0] NI_L   = LW'(NI);
   localparam logic [TW-1:0] NA_L   = TW'(NA);
   localparam logic [TW-1:0] TMAX_L = TW'(NA + 1);

   g_state_t g_state, g_next;
   o_state_t o_state, o_next;

   logic          leap, last, sub, shift;
   logic          accept, add_beat, last_close, close, tcnt_ovf, ovf_next;
   logic [LW-1:0] lcnt, lcnt_inc;
   logic [TW-1:0] tcnt;
   logic          ovf_q;
   logic [NB*AW-1:0] lane_acc;
   logic [NB-1:0]    lane_ovf;

   assign leap = iData_AS[idx_leap(DW)];
   assign last = iData_AS[idx_last(DW)];
   assign sub  = iData_AS[idx_sub(NB, WD)];

   if (RC) begin : g_shift
      assign shift = iData_AS[idx_shift(NB, WD)];
   end else begin : g_noshift
      assign shift = 1'b0;
   end

   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [WD-1:0] w;
      logic [WD:0]   term;
      assign w    = iData_AS[gi*WD +: WD];
      assign term = shift ? {w, 1'b0} : {1'b0, w};
      accum_lane #(.AW(AW), .WD(WD), .SAT(SAT)) u_lane (
         .iCLK  (iCLK),
         .iRST  (iRST),
         .init  (close),
         .valid (add_beat),
         .sub   (sub),
         .data  (term),
         .acc   (lane_acc[gi*AW +: AW]),
         .ovf   (lane_ovf[gi])
      );
   end

   assign oValid_BS = (o_state == O_FULL);
   assign oReady_AS = (o_state != O_FULL) || iReady_BS;

   // Beat acceptance, group-close decision and the group's running ovf flag.
   always_comb begin
      accept     = iValid_AS && oReady_AS;
      add_beat   = accept && !leap;
      lcnt_inc   = lcnt + LW'(1);
      last_close = add_beat && last && (lcnt_inc == NI_L);
      close      = accept && (leap || last_close);
      tcnt_ovf   = add_beat && (tcnt >= NA_L);
      ovf_next   = ovf_q || tcnt_ovf || (|lane_ovf);
   end

   // Next-state logic for the group and output state machines.
   always_comb begin
      g_next = g_state;
      o_next = o_state;
      if (accept)
         g_next = close ? G_IDLE : G_ACC;
      case (o_state)
         O_EMPTY: if (close) o_next = O_FULL;
         O_FULL:  if (!close && iReady_BS) o_next = O_EMPTY;
         default: o_next = O_EMPTY;
      endcase
   end

   // State registers for both machines.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         g_state <= G_IDLE;
         o_state <= O_EMPTY;
      end else begin
         g_state <= g_next;
         o_state <= o_next;
      end
   end

   // Per-group counters and flag; everything restarts when a group closes.
   always_ff @(posedge iCLK) begin
      if (iRST || close) begin
         lcnt  <= '0;
         tcnt  <= '0;
         ovf_q <= 1'b0;
      end else if (add_beat) begin
         if (last)
            lcnt <= lcnt_inc;
         if (tcnt != TMAX_L)
            tcnt <= tcnt + TW'(1);
         ovf_q <= ovf_next;
      end
   end

   // Output register captures the finished group, including the closing beat.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         oData_BS <= '0;
         oLeap_BS <= 1'b0;
         oOvf_BS  <= 1'b0;
      end else if (close) begin
         oData_BS <= lane_acc;
         oLeap_BS <= leap;
         oOvf_BS  <= ovf_next;
      end
   end

endmodule

// File: tb/tb_neuron_accum_multi.sv
// Directed self-checking bench: three accumulator instances (wrap/NI=1,
// NI=2, saturating) share one stimulus stream and are checked per scenario.
module tb_neuron_accum_multi;

   localparam int DW = 12;
   localparam int OW = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          valid_in = 1'b0;
   logic          ready_in = 1'b1;
   logic [DW-1:0] data_in = '0;

   logic          ready_a, valid_a, leap_a, ovf_a;
   logic          ready_n, valid_n, leap_n, ovf_n;
   logic          ready_s, valid_s, leap_s, ovf_s;
   logic [OW-1:0] data_a, data_n, data_s;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   neuron_accum_multi #(.NA(4), .NB(4), .WD(2), .NI(1), .MODE("rc"), .SAT(0)) dut_a (
      .iCLK(clk), .iRST(rst), .iValid_AS(valid_in), .oReady_AS(ready_a),
      .iData_AS(data_in), .oValid_BS(valid_a), .iReady_BS(ready_in),
      .oData_BS(data_a), .oLeap_BS(leap_a), .oOvf_BS(ovf_a));

   neuron_accum_multi #(.NA(4), .NB(4), .WD(2), .NI(2), .MODE("rc"), .SAT(0)) dut_n (
      .iCLK(clk), .iRST(rst), .iValid_AS(valid_in), .oReady_AS(ready_n),
      .iData_AS(data_in), .oValid_BS(valid_n), .iReady_BS(ready_in),
      .oData_BS(data_n), .oLeap_BS(leap_n), .oOvf_BS(ovf_n));

   neuron_accum_multi #(.NA(4), .NB(4), .WD(2), .NI(1), .MODE("rc"), .SAT(1)) dut_s (
      .iCLK(clk), .iRST(rst), .iValid_AS(valid_in), .oReady_AS(ready_s),
      .iData_AS(data_in), .oValid_BS(valid_s), .iReady_BS(ready_in),
      .oData_BS(data_s), .oLeap_BS(leap_s), .oOvf_BS(ovf_s));

   function automatic logic [OW-1:0] lanes4(input logic [4:0] v);
      return {v, v, v, v};
   endfunction

   task automatic do_reset();
      rst = 1'b1; valid_in = 1'b0; ready_in = 1'b1; data_in = '0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic send(input logic [7:0] w, input logic sub, input logic shift,
                       input logic last, input logic leap);
      data_in  = {leap, last, shift, sub, w};
      valid_in = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0;
      data_in  = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if ({valid_a, valid_n, valid_s} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_valid: got %b required 000", {valid_a, valid_n, valid_s}); end
      n_checks++; if (data_a !== '0) begin n_fail++; $display("[TB] FAIL reset_data: got %h required 0", data_a); end
      n_checks++; if ({leap_a, ovf_a, leap_s, ovf_s} !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b required 0000", {leap_a, ovf_a, leap_s, ovf_s}); end
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b required 1", ready_a); end
      n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid_after: got %b required 0", valid_a); end
   endtask

   task automatic test_basic();
      do_reset();
      send(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
      n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_no_early: got %b required 0", valid_a); end
      send(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_valid: got %b required 1", valid_a); end
      n_checks++; if (data_a !== lanes4(5'd7)) begin n_fail++; $display("[TB] FAIL basic_data: got %h required %h", data_a, lanes4(5'd7)); end
      n_checks++; if ({leap_a, ovf_a} !== 2'b00) begin n_fail++; $display("[TB] FAIL basic_flags: got %b required 00", {leap_a, ovf_a}); end
      @(posedge clk); #1;
      n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_drain: got %b required 0", valid_a); end
      send(8'b11_10_01_00, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++; if (data_a !== {5'd3, 5'd2, 5'd1, 5'd0}) begin n_fail++; $display("[TB] FAIL basic_lane_order: got %h required %h", data_a, {5'd3, 5'd2, 5'd1, 5'd0}); end
   endtask

   task automatic test_sub();
      do_reset();
      send(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      send(8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
      n_checks++; if (data_a !== lanes4(5'd2) || ovf_a !== 1'b0) begin n_fail++; $display("[TB] FAIL sub_basic: got %h ovf %b required %h ovf 0", data_a, ovf_a, lanes4(5'd2)); end
      send(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
      send(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++; if (data_a !== lanes4(5'd2) || ovf_a !== 1'b1) begin n_fail++; $display("[TB] FAIL sub_wrap: got %h ovf %b required %h ovf 1", data_a, ovf_a, lanes4(5'd2)); end
      n_checks++; if (data_s !== lanes4(5'd3) || ovf_s !== 1'b1) begin n_fail++; $display("[TB] FAIL sub_clamp: got %h ovf %b required %h ovf 1", data_s, ovf_s, lanes4(5'd3)); end
   endtask

   task automatic test_ni2();
      do_reset();
      send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      send(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++; if (valid_n !== 1'b0) begin n_fail++; $display("[TB] FAIL ni2_no_result: got %b required 0", valid_n); end
      send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      send(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++; if (valid_n !== 1'b1) begin n_fail++; $display("[TB] FAIL ni2_valid: got %b required 1", valid_n); end
      n_checks++; if (data_n !== lanes4(5'd4) || ovf_n !== 1'b0) begin n_fail++; $display("[TB] FAIL ni2_data: got %h ovf %b required %h ovf 0", data_n, ovf_n, lanes4(5'd4)); end
      n_checks++; if (data_a !== lanes4(5'd2)) begin n_fail++; $display("[TB] FAIL ni1_second_group: got %h required %h", data_a, lanes4(5'd2)); end
   endtask

   task automatic test_leap();
      do_reset();
      send(8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
      send(8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
      send(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      n_checks++; if (valid_a !== 1'b1 || data_a !== lanes4(5'd4)) begin n_fail++; $display("[TB] FAIL leap_data: got v%b %h required v1 %h", valid_a, data_a, lanes4(5'd4)); end
      n_checks++; if ({leap_a, ovf_a} !== 2'b10) begin n_fail++; $display("[TB] FAIL leap_flags: got %b required 10", {leap_a, ovf_a}); end
      n_checks++; if (data_n !== lanes4(5'd4) || leap_n !== 1'b1) begin n_fail++; $display("[TB] FAIL leap_ni2: got %h leap %b required %h leap 1", data_n, leap_n, lanes4(5'd4)); end
      send(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++; if (data_a !== lanes4(5'd1) || leap_a !== 1'b0) begin n_fail++; $display("[TB] FAIL leap_restart: got %h leap %b required %h leap 0", data_a, leap_a, lanes4(5'd1)); end
      n_checks++; if (valid_n !== 1'b0) begin n_fail++; $display("[TB] FAIL leap_last_ignored: got %b required 0", valid_n); end
      send(8'hFF, 1'b0, 1'b1, 1'b0, 1'b1);
      n_checks++; if (data_a !== '0 || {leap_a, ovf_a} !== 2'b10) begin n_fail++; $display("[TB] FAIL leap_only: got %h flags %b required 0 flags 10", data_a, {leap_a, ovf_a}); end
      n_checks++; if (data_n !== lanes4(5'd1) || leap_n !== 1'b1) begin n_fail++; $display("[TB] FAIL leap_partial_ni2: got %h leap %b required %h leap 1", data_n, leap_n, lanes4(5'd1)); end
   endtask

   task automatic test_term_count();
      do_reset();
      for (int i = 0; i < 4; i++) send(8'h00, 1'b0, 1'b0, (i == 3), 1'b0);
      n_checks++; if (valid_a !== 1'b1 || ovf_a !== 1'b0) begin n_fail++; $display("[TB] FAIL terms_at_limit: got v%b ovf %b required v1 ovf 0", valid_a, ovf_a); end
      for (int i = 0; i < 5; i++) send(8'h00, 1'b0, 1'b0, (i == 4), 1'b0);
      n_checks++; if (data_a !== '0 || ovf_a !== 1'b1) begin n_fail++; $display("[TB] FAIL terms_over_limit: got %h ovf %b required 0 ovf 1", data_a, ovf_a); end
   endtask

   task automatic test_sat();
      do_reset();
      for (int i = 0; i < 16; i++) send(8'hFF, 1'b0, 1'b0, (i == 15), 1'b0);
      n_checks++; if (data_s !== lanes4(5'd31) || ovf_s !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_clamp: got %h ovf %b required %h ovf 1", data_s, ovf_s, lanes4(5'd31)); end
      n_checks++; if (data_a !== lanes4(5'd16) || ovf_a !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_wrap: got %h ovf %b required %h ovf 1", data_a, ovf_a, lanes4(5'd16)); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      ready_in = 1'b0;
      send(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++; if (valid_a !== 1'b1 || data_a !== lanes4(5'd1)) begin n_fail++; $display("[TB] FAIL b2b_first: got v%b %h required v1 %h", valid_a, data_a, lanes4(5'd1)); end
      data_in = {1'b0, 1'b1, 1'b0, 1'b0, 8'hAA};
      valid_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_checks++; if (ready_a !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_stall_ready: cycle %0d got %b required 0", i, ready_a); end
         n_checks++; if (valid_a !== 1'b1 || data_a !== lanes4(5'd1)) begin n_fail++; $display("[TB] FAIL b2b_hold: cycle %0d got v%b %h required v1 %h", i, valid_a, data_a, lanes4(5'd1)); end
      end
      ready_in = 1'b1;
      #1;
      n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_ready_follow: got %b required 1", ready_a); end
      @(posedge clk); #1;
      valid_in = 1'b0;
      data_in  = '0;
      n_checks++; if (valid_a !== 1'b1 || data_a !== lanes4(5'd2)) begin n_fail++; $display("[TB] FAIL b2b_second: got v%b %h required v1 %h", valid_a, data_a, lanes4(5'd2)); end
      @(posedge clk); #1;
      n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_empty: got %b required 0", valid_a); end
      send(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++; if (data_a !== lanes4(5'd1)) begin n_fail++; $display("[TB] FAIL b2b_no_extra_adds: got %h required %h", data_a, lanes4(5'd1)); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      send(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_valid: got %b required 0", valid_a); end
      send(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++; if (data_a !== lanes4(5'd1)) begin n_fail++; $display("[TB] FAIL rstmid_discard: got %h required %h", data_a, lanes4(5'd1)); end
      ready_in = 1'b0;
      send(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("[TB] FAIL rstpend_full: got %b required 1", valid_a); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++; if (valid_a !== 1'b0 || data_a !== '0) begin n_fail++; $display("[TB] FAIL rstpend_cleared: got v%b %h required v0 0", valid_a, data_a); end
      n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("[TB] FAIL rstpend_ready: got %b required 1", ready_a); end
      ready_in = 1'b1;
      send(8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++; if (valid_a !== 1'b1 || data_a !== lanes4(5'd2)) begin n_fail++; $display("[TB] FAIL rstpend_next: got v%b %h required v1 %h", valid_a, data_a, lanes4(5'd2)); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sub();
      test_ni2();
      test_leap();
      test_term_count();
      test_sat();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
